psram_qpi_responder: RTL and testbench
======================================

Name: psram_qpi_responder

Overview:
- Synthesizable single-chip QPI PSRAM device model: the responder end of our PSRAM controller's link, for simulation and board loopback on a spare FPGA.
- Oversamples chip-select, SCLK and the 4-bit SIO bus in the i_clk domain.
- Accepts the serial enter-QPI command, then the QPI read (EBh), write (38h) and exit-QPI (F5h) commands against an internal byte array.
- Includes a backdoor read port for bench checking.

Parameters:
- ADDR_BITS, 10: internal array is 2**ADDR_BITS bytes; upper received address bits are ignored (aliasing).
- WAIT_CYCLES, 6: dummy SCLK rising edges between the last address nibble and the first read data nibble.
- SPI_DIN_LANE, 0: SIO lane carrying serial command bits before QPI entry (0..3).

Ports:
- i_clk  in  1  system clock; must be at least 4x the SCLK frequency.
- i_rst  in  1  synchronous, active-high reset.
- i_psram_csn  in  1  chip select, active low.
- i_psram_sclk  in  1  PSRAM serial clock (sampled as data).
- i_sio  in  4  SIO bus as driven by the controller.
- o_sio  out  4  read data nibble.
- o_sio_oe  out  1  high while the responder drives o_sio.
- o_qpi  out  1  QPI mode active.
- o_busy  out  1  csn (synchronized) low.
- o_state  out  3  debug state code.
- i_bd_addr  in  ADDR_BITS  backdoor read address.
- o_bd_data  out  8  array[i_bd_addr], registered, 1-cycle latency.

Behaviour:
- Reset values: o_sio=0, o_sio_oe=0, o_qpi=0, o_busy=0, o_state=ST_IDLE, o_bd_data=0. All counters are cleared. The array is not cleared.
- Reset mid-transaction aborts it immediately and drops QPI mode.
- Input sampling: csn, sclk and sio pass through 2 flops; a third sclk flop provides edge detect.
  - Rise = s2 & ~s3; fall = ~s2 & s3.
  - Effective response latency is 2-3 i_clk cycles after a pin change.
- csn high (synchronized) always wins:
  - next state is ST_IDLE, o_sio_oe=0, any pending half byte is discarded;
  - an edge seen in the same cycle is ignored;
  - o_qpi is unaffected.
- States:
  - ST_IDLE: on csn low, go to ST_CMD.
  - ST_CMD, serial (o_qpi=0): shift the SPI_DIN_LANE bit, MSB first, on each rise. After 8 bits:
    - 35h sets o_qpi=1 and goes to ST_IGNORE;
    - anything else goes to ST_IGNORE.
  - ST_CMD, QPI (o_qpi=1): shift i_sio on each rise, high nibble first. After 2 nibbles:
    - EBh goes to ST_ADDR (read);
    - 38h goes to ST_ADDR (write);
    - F5h clears o_qpi, then ST_IGNORE;
    - others go to ST_IGNORE.
  - ST_ADDR: 6 nibbles on rises, A[23:20] first, into a 24-bit register.
    - After the 6th: read goes to ST_WAIT with dummy count 0; write goes to ST_WR.
    - If WAIT_CYCLES==0, read goes straight to ST_RD and the first nibble is driven on the next fall.
  - ST_WAIT: count rises. On the WAIT_CYCLES-th rise go to ST_RD.
  - ST_RD:
    - On each fall, drive o_sio with the current nibble (high nibble, then low nibble) and set o_sio_oe=1. The first drive is on the fall after the last dummy rise.
    - After the low nibble of a byte is driven, address = (address+1) mod 2**ADDR_BITS.
    - Streams indefinitely until csn high.
  - ST_WR:
    - Nibble pairs received on rises, high nibble first.
    - The byte is written to the array on the rise delivering the second nibble, then address increments with wrap.
    - An odd trailing nibble is discarded.
  - ST_IGNORE: no response until csn high.
- o_sio_oe is high only in ST_RD; o_sio holds its last value when oe=0.
- o_state codes: IDLE=0, CMD=1, ADDR=2, WAIT=3, RD=4, WR=5, IGNORE=6.
- Array: one write port (protocol) and two read ports (protocol read, backdoor). Inferred as RAM.

Decomposition:
- Package psram_pkg holds:
  - command constants CMD_ENTER_QPI=8'h35, CMD_QREAD=8'hEB, CMD_QWRITE=8'h38, CMD_EXIT_QPI=8'hF5;
  - the responder state enum, shared with the existing controller's command values.
- One sub-module, psram_pin_sync: 2-flop synchronizers for csn, sclk and sio, plus sclk rise/fall detect.

Test Plan:
1. Reset, then serial 35h on lane 0 and csn high -> o_qpi=1, o_state back to 0, o_sio_oe stays 0.
2. QPI write 38h, addr 000010h, data A5h,3Ch -> backdoor 010h=A5h, 011h=3Ch; other locations unchanged.
3. QPI read EBh, addr 000010h, 6 dummy clocks, 4 data clocks -> nibbles A,5,3,C on successive falls; oe rises on the fall after the 6th dummy rise.
4. Wrap (ADDR_BITS=10): write addr 0003FFh with data 11h,22h -> 3FFh=11h, 000h=22h. Read back from 0003FFh gives 11h,22h.
5. Abort: csn high after 3 nibbles of a write, and after 1 data nibble of a read -> no array change, oe=0 within 3 i_clk cycles, next command decodes normally.
6. i_rst high mid-read -> o_sio_oe=0, o_qpi=0 next cycle; array retained; serial 35h required before further QPI commands. Unknown QPI command 9Fh -> ST_IGNORE, no drive.

Source files
------------

// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared PSRAM command codes and responder state encoding
// Contents: QPI/SPI command bytes used by controller and responder,
//           responder state enum (values appear on o_state for debug).
package psram_pkg;

  localparam logic [7:0] CMD_ENTER_QPI = 8'h35;
  localparam logic [7:0] CMD_QREAD     = 8'hEB;
  localparam logic [7:0] CMD_QWRITE    = 8'h38;
  localparam logic [7:0] CMD_EXIT_QPI  = 8'hF5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RD     = 3'd4,
    ST_WR     = 3'd5,
    ST_IGNORE = 3'd6
  } psram_state_t;

endpackage

// File: rtl/psram_pin_sync.sv
// rtl/psram_pin_sync.sv - pin synchronizers and SCLK edge detect
// Ports: i_clk/i_rst      system clock, sync active-high reset
//        i_csn/i_sclk/i_sio raw pins
//        o_csn/o_sio       2-flop synchronized copies
//        o_sclk_rise/fall  single-cycle SCLK edge strobes
module psram_pin_sync (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_csn,
  input  logic       i_sclk,
  input  logic [3:0] i_sio,
  output logic       o_csn,
  output logic       o_sclk_rise,
  output logic       o_sclk_fall,
  output logic [3:0] o_sio
);

  logic       csn_s1, csn_s2;
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic [3:0] sio_s1, sio_s2;

  // csn resets deasserted so the responder comes out of reset idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      csn_s1  <= 1'b1;
      csn_s2  <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      sio_s1  <= 4'h0;
      sio_s2  <= 4'h0;
    end else begin
      csn_s1  <= i_csn;
      csn_s2  <= csn_s1;
      sclk_s1 <= i_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      sio_s1  <= i_sio;
      sio_s2  <= sio_s1;
    end
  end

  assign o_csn       = csn_s2;
  assign o_sio       = sio_s2;
  assign o_sclk_rise = sclk_s2 & ~sclk_s3;
  assign o_sclk_fall = ~sclk_s2 & sclk_s3;

endmodule

// File: rtl/psram_qpi_responder.sv
// rtl/psram_qpi_responder.sv - QPI PSRAM device model (responder side)
// Ports: i_clk/i_rst       system clock (>= 4x SCLK), sync active-high reset
//        i_psram_csn/sclk  link pins, oversampled
//        i_sio/o_sio/o_sio_oe  SIO bus in, read nibble out, output enable
//        o_qpi/o_busy/o_state  mode, csn-active, debug state code
//        i_bd_addr/o_bd_data   backdoor array read, 1-cycle latency
module psram_qpi_responder
  import psram_pkg::*;
#(
  parameter int ADDR_BITS    = 10,
  parameter int WAIT_CYCLES  = 6,
  parameter int SPI_DIN_LANE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_psram_csn,
  input  logic                 i_psram_sclk,
  input  logic [3:0]           i_sio,
  output logic [3:0]           o_sio,
  output logic                 o_sio_oe,
  output logic                 o_qpi,
  output logic                 o_busy,
  output logic [2:0]           o_state,
  input  logic [ADDR_BITS-1:0] i_bd_addr,
  output logic [7:0]           o_bd_data
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int WCW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic                 csn_s, rise, fall;
  logic [3:0]           sio_s;

  psram_state_t         state;
  logic                 qpi;
  logic [7:0]           cmd_sr;
  logic [2:0]           cnt;
  logic                 is_read;
  logic [ADDR_BITS-1:0] addr;
  logic [WCW-1:0]       wait_cnt;
  logic                 have_hi;
  logic [3:0]           wr_hi;
  logic                 rd_lo;
  logic [7:0]           mem [DEPTH];

  logic [7:0]           cmd_next;
  logic [7:0]           rd_byte;
  logic                 wr_en;

  psram_pin_sync u_sync (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_csn       (i_psram_csn),
    .i_sclk      (i_psram_sclk),
    .i_sio       (i_sio),
    .o_csn       (csn_s),
    .o_sclk_rise (rise),
    .o_sclk_fall (fall),
    .o_sio       (sio_s)
  );

  // Serial mode shifts one lane per rise, QPI mode a full nibble.
  assign cmd_next = qpi ? {cmd_sr[3:0], sio_s} : {cmd_sr[6:0], sio_s[SPI_DIN_LANE]};
  assign rd_byte  = mem[addr];
  assign wr_en    = (state == ST_WR) && !csn_s && rise && have_hi;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      qpi      <= 1'b0;
      cmd_sr   <= 8'h00;
      cnt      <= 3'd0;
      is_read  <= 1'b0;
      addr     <= '0;
      wait_cnt <= '0;
      have_hi  <= 1'b0;
      wr_hi    <= 4'h0;
      rd_lo    <= 1'b0;
      o_sio    <= 4'h0;
      o_sio_oe <= 1'b0;
    end else if (csn_s) begin
      // Deselect overrides any edge in the same cycle; QPI mode persists.
      state    <= ST_IDLE;
      o_sio_oe <= 1'b0;
      have_hi  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_CMD;
          cnt   <= 3'd0;
        end
        ST_CMD: if (rise) begin
          cmd_sr <= cmd_next;
          cnt    <= cnt + 3'd1;
          if (!qpi && cnt == 3'd7) begin
            if (cmd_next == CMD_ENTER_QPI) qpi <= 1'b1;
            state <= ST_IGNORE;
          end else if (qpi && cnt == 3'd1) begin
            cnt <= 3'd0;
            case (cmd_next)
              CMD_QREAD:    begin is_read <= 1'b1; state <= ST_ADDR; end
              CMD_QWRITE:   begin is_read <= 1'b0; state <= ST_ADDR; end
              CMD_EXIT_QPI: begin qpi <= 1'b0; state <= ST_IGNORE; end
              default:      state <= ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: if (rise) begin
          // Bits shifted past the array width fall off: address aliasing.
          addr <= ADDR_BITS'({addr, sio_s});
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd5) begin
            cnt      <= 3'd0;
            rd_lo    <= 1'b0;
            have_hi  <= 1'b0;
            wait_cnt <= '0;
            if (is_read) state <= (WAIT_CYCLES == 0) ? ST_RD : ST_WAIT;
            else         state <= ST_WR;
          end
        end
        ST_WAIT: if (rise) begin
          if (wait_cnt == WCW'(WAIT_CYCLES - 1)) state <= ST_RD;
          else wait_cnt <= wait_cnt + WCW'(1);
        end
        ST_RD: if (fall) begin
          o_sio    <= rd_lo ? rd_byte[3:0] : rd_byte[7:4];
          o_sio_oe <= 1'b1;
          rd_lo    <= ~rd_lo;
          if (rd_lo) addr <= addr + ADDR_BITS'(1);
        end
        ST_WR: if (rise) begin
          if (!have_hi) begin
            wr_hi   <= sio_s;
            have_hi <= 1'b1;
          end else begin
            have_hi <= 1'b0;
            addr    <= addr + ADDR_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Array kept free of reset so it maps onto block/distributed RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[addr] <= {wr_hi, sio_s};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_bd_data <= 8'h00;
    else       o_bd_data <= mem[i_bd_addr];
  end

  assign o_qpi   = qpi;
  assign o_busy  = ~csn_s;
  assign o_state = state;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// tb/tb_psram_qpi_responder.sv - randomized scoreboard bench for psram_qpi_responder
module tb_psram_qpi_responder;

  localparam int AB    = 10;
  localparam int DEPTH = 1 << AB;
  localparam int WAITC = 6;
  localparam int LANE  = 0;

  logic          i_clk, i_rst, i_psram_csn, i_psram_sclk;
  logic [3:0]    i_sio, o_sio;
  logic          o_sio_oe, o_qpi, o_busy;
  logic [2:0]    o_state;
  logic [AB-1:0] i_bd_addr;
  logic [7:0]    o_bd_data;

  psram_qpi_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(WAITC), .SPI_DIN_LANE(LANE)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_psram_csn(i_psram_csn), .i_psram_sclk(i_psram_sclk),
    .i_sio(i_sio), .o_sio(o_sio), .o_sio_oe(o_sio_oe), .o_qpi(o_qpi), .o_busy(o_busy),
    .o_state(o_state), .i_bd_addr(i_bd_addr), .o_bd_data(o_bd_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed { logic oe; logic [3:0] nib; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] wq[$];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One SCLK period of 8 i_clk cycles; the expectation for the coming fall is queued first.
  task automatic tick(input logic [3:0] v, input logic eoe, input logic [3:0] enib);
    i_sio = v;
    repeat (4) @(negedge i_clk);
    i_psram_sclk = 1'b1;
    repeat (4) @(negedge i_clk);
    exp_q.push_back({eoe, enib});
    i_psram_sclk = 1'b0;
  endtask

  task automatic cs_begin();
    i_psram_csn = 1'b0;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge i_clk);
    i_psram_csn = 1'b1;
    repeat (6) @(negedge i_clk);
  endtask

  task automatic ser_cmd(input logic [7:0] c);
    logic [3:0] v;
    cs_begin();
    chk("busy_in_cmd", o_busy, 1);
    chk("state_cmd", o_state, 1);
    for (int i = 7; i >= 0; i--) begin
      v = 4'($urandom);
      v[LANE] = c[i];
      tick(v, 1'b0, 4'h0);
    end
    cs_end();
  endtask

  task automatic q_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) tick(a[4*i +: 4], 1'b0, 4'h0);
  endtask

  // Writes bytes from wq starting at a, then optionally one stray nibble.
  task automatic q_write(input logic [23:0] a, input int extra_nib);
    cs_begin();
    tick(4'h3, 1'b0, 4'h0);
    tick(4'h8, 1'b0, 4'h0);
    q_addr(a);
    for (int k = 0; k < wq.size(); k++) begin
      tick(wq[k][7:4], 1'b0, 4'h0);
      tick(wq[k][3:0], 1'b0, 4'h0);
      ref_mem[(int'(a) + k) % DEPTH] = wq[k];
    end
    if (extra_nib != 0) tick(4'($urandom), 1'b0, 4'h0);
    cs_end();
  endtask

  // Drives a read up to nnib data nibbles; the last dummy clock's fall carries nibble 0.
  task automatic q_read_start(input logic [23:0] a, input int nnib);
    logic [7:0] b;
    cs_begin();
    tick(4'hE, 1'b0, 4'h0);
    tick(4'hB, 1'b0, 4'h0);
    q_addr(a);
    for (int i = 0; i < WAITC - 1; i++) tick(4'($urandom), 1'b0, 4'h0);
    for (int k = 0; k < nnib; k++) begin
      b = ref_mem[(int'(a) + k / 2) % DEPTH];
      tick(4'($urandom), 1'b1, (k % 2 == 1) ? b[3:0] : b[7:4]);
    end
  endtask

  task automatic q_read(input logic [23:0] a, input int nbytes);
    q_read_start(a, 2 * nbytes);
    cs_end();
  endtask

  task automatic bd_chk(input int a);
    i_bd_addr = AB'(a);
    @(negedge i_clk);
    @(negedge i_clk);
    chk($sformatf("bd_%0h", a), o_bd_data, ref_mem[a]);
  endtask

  // Monitor: every SCLK fall, after the sync latency, compare against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_psram_sclk);
      repeat (4) @(negedge i_clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_underflow: fall with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        chk("mon_oe", o_sio_oe, e.oe);
        if (e.oe) chk("mon_nib", o_sio, e.nib);
      end
    end
  end

  initial begin
    repeat (90000) @(posedge i_clk);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1);
  end

  initial begin
    logic [23:0] ra;
    int          rn;
    i_rst = 1'b1; i_psram_csn = 1'b1; i_psram_sclk = 1'b0; i_sio = 4'h0; i_bd_addr = '0;
    repeat (5) @(negedge i_clk);
    chk("rst_sio", o_sio, 0);
    chk("rst_oe", o_sio_oe, 0);
    chk("rst_qpi", o_qpi, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_state", o_state, 0);
    chk("rst_bd", o_bd_data, 0);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);

    // Non-enter serial command leaves serial mode, then enter QPI.
    ser_cmd(8'h66);
    chk("qpi_after_66", o_qpi, 0);
    ser_cmd(8'h35);
    chk("qpi_after_35", o_qpi, 1);
    chk("idle_after_35", o_state, 0);

    // Fill the whole array so every later read is of known data.
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(8'($urandom));
    q_write(24'h000000, 0);

    wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h3C);
    q_write(24'h000010, 0);
    bd_chk(16); bd_chk(17); bd_chk(15); bd_chk(18);
    q_read(24'h000010, 2);

    // Wrap at the top of the array.
    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
    q_write(24'h0003FF, 0);
    bd_chk(1023); bd_chk(0);
    q_read(24'h0003FF, 2);

    // Random traffic; upper address bits must alias.
    for (int it = 0; it < 10; it++) begin
      ra = 24'($urandom);
      rn = $urandom_range(1, 5);
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i < rn; i++) wq.push_back(8'($urandom));
        q_write(ra, 0);
      end else begin
        q_read(ra, rn);
      end
    end

    // Abort inside the address phase: nothing written.
    cs_begin();
    tick(4'h3, 1'b0, 4'h0);
    tick(4'h8, 1'b0, 4'h0);
    tick(4'h0, 1'b0, 4'h0);
    cs_end();
    // Odd trailing nibble after one full byte is dropped.
    wq.delete(); wq.push_back(8'h5A);
    q_write(24'h000100, 1);
    bd_chk(256); bd_chk(257);
    // Read aborted after one data nibble.
    q_read_start(24'h000100, 1);
    repeat (4) @(negedge i_clk);
    i_psram_csn = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("abort_rd_oe", o_sio_oe, 0);
    repeat (3) @(negedge i_clk);
    q_read(24'h000100, 2);

    // Exit QPI, re-enter.
    cs_begin();
    tick(4'hF, 1'b0, 4'h0);
    tick(4'h5, 1'b0, 4'h0);
    cs_end();
    chk("qpi_after_f5", o_qpi, 0);
    ser_cmd(8'h35);
    chk("qpi_reenter", o_qpi, 1);

    // Reset mid-read.
    q_read_start(24'h000020, 3);
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rst_mid_oe", o_sio_oe, 0);
    chk("rst_mid_qpi", o_qpi, 0);
    chk("rst_mid_state", o_state, 0);
    i_rst = 1'b0;
    i_psram_csn = 1'b1;
    repeat (6) @(negedge i_clk);

    // QPI read attempted in serial mode: lane-0 bits form 40h, ignored.
    cs_begin();
    tick(4'hE, 1'b0, 4'h0);
    tick(4'hB, 1'b0, 4'h0);
    for (int i = 0; i < 6 + WAITC + 4; i++) tick(4'h0, 1'b0, 4'h0);
    chk("serial_ignore_state", o_state, 6);
    cs_end();
    chk("serial_ignore_qpi", o_qpi, 0);

    ser_cmd(8'h35);
    // Unknown QPI command.
    cs_begin();
    tick(4'h9, 1'b0, 4'h0);
    tick(4'hF, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) tick(4'($urandom), 1'b0, 4'h0);
    chk("unknown_state", o_state, 6);
    cs_end();
    chk("unknown_qpi", o_qpi, 1);

    q_read(24'h0003FE, 3);

    // Array retained across reset and aborts.
    for (int a = 0; a < DEPTH; a++) bd_chk(a);

    repeat (4) @(negedge i_clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
